sonar_scanner: RTL and testbench

- Multi-channel successor to the single HC-SR04-style ranger.
- Fires NUM_CH ultrasonic sensors one at a time in round-robin order, so one sensor's echo cannot be picked up by another.
- Measures each echo high-time in clk cycles and handles a missing or stuck echo with timeouts.
- Publishes per-channel results, a per-result strobe, and the nearest channel of each full sweep, for downstream display and conversion blocks.

---
 rtl/sonar_scanner.sv | 233 +++++++++++++++++++++++
 tb/tb_sonar_scanner.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_scanner.sv
// -----------------------------------------------------------------------------
// sonar_scanner
//
// Round-robin multi-channel ultrasonic ranger (HC-SR04 style). The block
// triggers one sensor at a time and measures its echo high-time in clk cycles.
// A missing rising edge or an over-long echo produces a timeout result. The
// block keeps the last result of every channel and reports the nearest valid
// channel of each complete sweep.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   enable         run scanning; a low level stops the scan at the next
//                  GAP->TRIG boundary
//   echo           raw asynchronous echo inputs, one per channel
//   trig           registered trigger outputs, at most one bit high
//   active_ch      channel currently being serviced
//   result_valid   one-cycle strobe; the result_* outputs change in that cycle
//   result_ch      channel of the latest result
//   result_cycles  latest echo width in cycles (TIMEOUT_CYCLES on timeout)
//   result_timeout the latest result was a rise or width timeout
//   dist_flat      last result per channel, channel k at [k*CNT_W +: CNT_W]
//   ch_valid       channel k holds a non-timeout result
//   sweep_done     one-cycle strobe after the last channel of a sweep
//   min_ch         channel with the smallest valid result of that sweep
//   min_cycles     that smallest value, all-ones if no channel was valid
// -----------------------------------------------------------------------------
module sonar_scanner #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 24,
  parameter int TRIG_CYCLES    = 120,
  parameter int RISE_TIMEOUT   = 60000,
  parameter int TIMEOUT_CYCLES = 456000,
  parameter int GAP_CYCLES     = 720000,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       echo,
  output logic [NUM_CH-1:0]       trig,
  output logic [CH_W-1:0]         active_ch,
  output logic                    result_valid,
  output logic [CH_W-1:0]         result_ch,
  output logic [CNT_W-1:0]        result_cycles,
  output logic                    result_timeout,
  output logic [NUM_CH*CNT_W-1:0] dist_flat,
  output logic [NUM_CH-1:0]       ch_valid,
  output logic                    sweep_done,
  output logic [CH_W-1:0]         min_ch,
  output logic [CNT_W-1:0]        min_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_DONE,
    S_GAP
  } state_t;

  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RISE_LAST   = CNT_W'(RISE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CH - 1);

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [CH_W-1:0]     ch_d;
  logic [NUM_CH-1:0]   echo_s1, echo_s2;
  logic                echo_sel, echo_prev;
  logic                fin, fin_to, ch_step, wrap;
  logic [CNT_W-1:0]    fin_val;
  logic [CNT_W-1:0]    run_min;
  logic [CH_W-1:0]     run_ch;

  // Echo of the serviced channel after the 2-FF synchronizer. echo_prev
  // follows it every cycle, so a level that is already high on entry to
  // WAIT_RISE never looks like a rising edge.
  assign echo_sel = echo_s2[active_ch];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next state, counter and per-channel completion.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    fin     = 1'b0;
    fin_to  = 1'b0;
    fin_val = cnt;
    ch_step = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable) begin
          state_d = S_TRIG;
          cnt_d   = '0;
        end
      end
      S_TRIG: begin
        if (cnt >= TRIG_LAST) begin
          state_d = S_WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_WAIT_RISE: begin
        if (echo_sel && !echo_prev) begin
          // The rise cycle is the first high cycle of the echo.
          state_d = S_MEASURE;
          cnt_d   = CNT_W'(1);
        end else if (cnt >= RISE_LAST) begin
          state_d = S_DONE;
          fin     = 1'b1;
          fin_to  = 1'b1;
          fin_val = TIMEOUT_VAL;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_MEASURE: begin
        // The fall is tested first, so a fall exactly at TIMEOUT_CYCLES is a
        // valid measurement. The counter stops at TIMEOUT_CYCLES and never wraps.
        if (!echo_sel) begin
          state_d = S_DONE;
          fin     = 1'b1;
        end else if (cnt >= TIMEOUT_VAL) begin
          state_d = S_DONE;
          fin     = 1'b1;
          fin_to  = 1'b1;
          fin_val = TIMEOUT_VAL;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_GAP;
        cnt_d   = '0;
      end
      S_GAP: begin
        if (cnt >= GAP_LAST) begin
          ch_step = 1'b1;
          state_d = enable ? S_TRIG : S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    wrap = ch_step && (active_ch == LAST_CH);
    ch_d = active_ch;
    if (ch_step) ch_d = wrap ? '0 : active_ch + 1'b1;
  end

  // Datapath and outputs. All outputs are registered. The fin decision is
  // latched on the edge that enters DONE, so result_valid and the result
  // registers change in the DONE cycle.
  // NOTE: the per-channel result store is reset as well, because it drives
  // outputs that must read zero straight after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_s1        <= '0;
      echo_s2        <= '0;
      echo_prev      <= 1'b0;
      trig           <= '0;
      active_ch      <= '0;
      result_valid   <= 1'b0;
      result_ch      <= '0;
      result_cycles  <= '0;
      result_timeout <= 1'b0;
      dist_flat      <= '0;
      ch_valid       <= '0;
      sweep_done     <= 1'b0;
      min_ch         <= '0;
      min_cycles     <= '1;
      run_min        <= '1;
      run_ch         <= '0;
    end else begin
      echo_s1      <= echo;
      echo_s2      <= echo_s1;
      echo_prev    <= echo_sel;
      active_ch    <= ch_d;
      result_valid <= fin;
      sweep_done   <= wrap;

      trig <= '0;
      if (state_d == S_TRIG) trig[ch_d] <= 1'b1;

      if (fin) begin
        result_ch                             <= active_ch;
        result_cycles                         <= fin_val;
        result_timeout                        <= fin_to;
        dist_flat[active_ch*CNT_W +: CNT_W]   <= fin_val;
        ch_valid[active_ch]                   <= !fin_to;
        // Strict less-than keeps the lower channel on ties.
        if (!fin_to && (fin_val < run_min)) begin
          run_min <= fin_val;
          run_ch  <= active_ch;
        end
      end

      // On wrap, publish the sweep minimum and restart the running minimum.
      // fin and wrap are never active in the same cycle.
      if (wrap) begin
        min_ch     <= run_ch;
        min_cycles <= run_min;
        run_min    <= '1;
        run_ch     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sonar_scanner.sv
// -----------------------------------------------------------------------------
// tb_sonar_scanner
//
// Directed bench for sonar_scanner. The stimulus process pushes the expected
// result of each channel visit into sb_q, and the expected sweep minimum into
// sw_q. A monitor pops and compares those entries whenever the DUT pulses
// result_valid or sweep_done.
// -----------------------------------------------------------------------------
module tb_sonar_scanner;

  localparam int NUM_CH         = 2;
  localparam int CNT_W          = 24;
  localparam int TRIG_CYCLES    = 4;
  localparam int RISE_TIMEOUT   = 20;
  localparam int TIMEOUT_CYCLES = 50;
  localparam int GAP_CYCLES     = 10;
  localparam int CH_W           = 1;
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  localparam int K_PULSE = 0;
  localparam int K_NEVER = 1;
  localparam int K_STUCK = 2;

  typedef struct {
    int ch;
    int cycles;
    bit to;
  } res_t;

  typedef struct {
    int         ch;
    logic [63:0] cycles;
    bit         chk_ch;
  } sweep_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    enable;
  logic [NUM_CH-1:0]       echo;
  logic [NUM_CH-1:0]       trig;
  logic [CH_W-1:0]         active_ch;
  logic                    result_valid;
  logic [CH_W-1:0]         result_ch;
  logic [CNT_W-1:0]        result_cycles;
  logic                    result_timeout;
  logic [NUM_CH*CNT_W-1:0] dist_flat;
  logic [NUM_CH-1:0]       ch_valid;
  logic                    sweep_done;
  logic [CH_W-1:0]         min_ch;
  logic [CNT_W-1:0]        min_cycles;

  int     checks = 0;
  int     errors = 0;
  res_t   sb_q[$];
  sweep_t sw_q[$];

  always #5 clk = ~clk;

  sonar_scanner #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TRIG_CYCLES(TRIG_CYCLES),
    .RISE_TIMEOUT(RISE_TIMEOUT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .echo(echo), .trig(trig),
    .active_ch(active_ch), .result_valid(result_valid), .result_ch(result_ch),
    .result_cycles(result_cycles), .result_timeout(result_timeout),
    .dist_flat(dist_flat), .ch_valid(ch_valid), .sweep_done(sweep_done),
    .min_ch(min_ch), .min_cycles(min_cycles)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every strobe against the head of its queue.
  always @(negedge clk) begin
    if (!reset && result_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: ch %0d cycles %0d with no entry queued", result_ch, result_cycles);
      end else begin
        res_t e;
        e = sb_q.pop_front();
        check("result_ch", result_ch, e.ch);
        check("result_cycles", result_cycles, e.cycles);
        check("result_timeout", result_timeout, e.to);
      end
    end
    if (!reset && sweep_done) begin
      if (sw_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sweep: min_cycles %0d with no entry queued", min_cycles);
      end else begin
        sweep_t s;
        s = sw_q.pop_front();
        check("min_cycles", min_cycles, s.cycles);
        if (s.chk_ch) check("min_ch", min_ch, s.ch);
      end
    end
  end

  // Services one channel visit: waits for the trigger, checks its width and
  // drives the echo. drop_en lowers enable in the middle of the trigger pulse.
  task automatic service(input int ch, input int kind, input int delay, input int width,
                         input int exp_cyc, input bit exp_to, input bit drop_en);
    bit ok;
    int n;
    int lat;
    logic [NUM_CH-1:0] oh;
    sb_q.push_back('{ch: ch, cycles: exp_cyc, to: exp_to});
    if (kind == K_STUCK) echo[ch] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (trig[ch]) begin ok = 1'b1; break; end
    end
    check("trig_start", ok, 1);
    oh = '0;
    oh[ch] = 1'b1;
    check("trig_onehot", trig, oh);
    n = 0;
    for (int i = 0; i < 100 && trig[ch]; i++) begin
      n++;
      if (drop_en && n == 2) enable = 1'b0;
      @(posedge clk); #1;
    end
    check("trig_width", n, TRIG_CYCLES);
    ok = 1'b0;
    if (kind == K_PULSE) begin
      repeat (delay) @(posedge clk);
      #1 echo[ch] = 1'b1;
      for (int i = 0; i < width; i++) begin
        @(posedge clk); #1;
        if (result_valid) ok = 1'b1;
      end
      echo[ch] = 1'b0;
    end
    lat = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      lat++;
      if (result_valid) ok = 1'b1;
    end
    check("result_seen", ok, 1);
    if (kind == K_PULSE && !exp_to) check("result_latency", lat, 3);
    if (kind == K_STUCK) echo[ch] = 1'b0;
  endtask

  initial begin
    bit ok;
    int n;
    reset  = 1'b1;
    enable = 1'b0;
    echo   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_trig", trig, 0);
    check("rst_active_ch", active_ch, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_dist_flat", dist_flat, 0);
    check("rst_ch_valid", ch_valid, 0);
    check("rst_min_cycles", min_cycles, ALL_ONES);
    check("rst_min_ch", min_ch, 0);
    reset  = 1'b0;
    enable = 1'b1;

    // Sweep 1: 30-cycle echo on ch0, no echo on ch1.
    service(0, K_PULSE, 5, 30, 30, 0, 0);
    check("s1_ch_valid_a", ch_valid, 2'b01);
    check("s1_dist0", dist_flat[CNT_W-1:0], 30);
    sw_q.push_back('{ch: 0, cycles: 30, chk_ch: 1});
    service(1, K_NEVER, 0, 0, TIMEOUT_CYCLES, 1, 0);
    check("s1_ch_valid_b", ch_valid, 2'b01);
    check("s1_dist1", dist_flat[2*CNT_W-1:CNT_W], TIMEOUT_CYCLES);

    // Sweep 2: ch0 stuck high, 12-cycle echo on ch1.
    service(0, K_STUCK, 0, 0, TIMEOUT_CYCLES, 1, 0);
    check("s2_ch_valid_a", ch_valid, 2'b00);
    sw_q.push_back('{ch: 1, cycles: 12, chk_ch: 1});
    service(1, K_PULSE, 3, 12, 12, 0, 0);
    check("s2_ch_valid_b", ch_valid, 2'b10);

    // Sweep 3: equal echoes, so the lower channel wins the tie.
    service(0, K_PULSE, 2, 12, 12, 0, 0);
    sw_q.push_back('{ch: 0, cycles: 12, chk_ch: 1});
    service(1, K_PULSE, 6, 12, 12, 0, 0);

    // Sweep 4: both channels time out (width overrun, missing rise).
    service(0, K_PULSE, 4, 60, TIMEOUT_CYCLES, 1, 0);
    sw_q.push_back('{ch: 0, cycles: ALL_ONES, chk_ch: 0});
    service(1, K_NEVER, 0, 0, TIMEOUT_CYCLES, 1, 0);
    check("s4_ch_valid", ch_valid, 2'b00);

    // Sweep 5: width exactly TIMEOUT_CYCLES is valid, one more times out.
    service(0, K_PULSE, 1, 50, 50, 0, 0);
    sw_q.push_back('{ch: 0, cycles: 50, chk_ch: 1});
    service(1, K_PULSE, 1, 51, TIMEOUT_CYCLES, 1, 0);
    check("s5_ch_valid", ch_valid, 2'b01);
    check("s5_dist0", dist_flat[CNT_W-1:0], 50);

    // Assert reset in the middle of a measurement.
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (trig[0]) begin ok = 1'b1; break; end
    end
    check("rm_trig_start", ok, 1);
    repeat (TRIG_CYCLES + 3) @(posedge clk);
    #1 echo[0] = 1'b1;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rm_trig", trig, 0);
    check("rm_result_valid", result_valid, 0);
    check("rm_dist_flat", dist_flat, 0);
    check("rm_ch_valid", ch_valid, 0);
    check("rm_active_ch", active_ch, 0);
    check("rm_min_cycles", min_cycles, ALL_ONES);
    echo   = '0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (trig != 0) n++;
    end
    check("rm_idle_no_trig", n, 0);

    // Drop enable during TRIG: the channel still completes, then the scan stops.
    enable = 1'b1;
    service(0, K_PULSE, 4, 8, 8, 0, 1);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (trig != 0) n++;
    end
    check("en_no_new_trig", n, 0);
    check("en_active_ch", active_ch, 1);

    check("sb_empty", sb_q.size(), 0);
    check("sw_empty", sw_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
